// File: rtl/seq_calculator_if.sv
// Request/response bundle for seq_calculator: one request channel, one response channel.
interface seq_calculator_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [1:0]           op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 error;

  modport master (
    output req_valid, a, b, op, rsp_ready,
    input  req_ready, rsp_valid, result, error
  );

  modport slave (
    input  req_valid, a, b, op, rsp_ready,
    output req_ready, rsp_valid, result, error
  );
endinterface

// File: rtl/seq_calculator.sv
// Sequential add/sub/mul/div unit: add/sub/div-by-zero answer in one edge, mul/div iterate
// one bit per cycle for WIDTH cycles. Response is held until rsp_ready.
module seq_calculator #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_calculator_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned RW   = 2 * WIDTH;
  localparam logic [1:0]  OpAdd = 2'b00;
  localparam logic [1:0]  OpSub = 2'b01;
  localparam logic [1:0]  OpMul = 2'b10;
  localparam logic [1:0]  OpDiv = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;      // multiplicand source / dividend-then-quotient
  logic [WIDTH-1:0]  b_q, b_d;      // multiplier (shifts right) / divisor
  logic [1:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [RW-1:0]     result_q, result_d;
  logic              error_q, error_d;

  logic [WIDTH:0]    shifted;
  logic              ge;
  logic [RW-1:0]     acc_step;

  always_comb begin
    shifted  = {rem_q, a_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, b_q});
    acc_step = b_q[0] ? (acc_q + mcand_q) : acc_q;

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    result_d = result_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          acc_d   = '0;
          rem_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, bus.a};
          error_d = 1'b0;
          unique case (bus.op)
            OpAdd: begin
              result_d = {{WIDTH{1'b0}}, bus.a} + {{WIDTH{1'b0}}, bus.b};
              state_d  = StDone;
            end
            OpSub: begin
              result_d = {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
              state_d  = StDone;
            end
            OpMul: state_d = StCalc;
            OpDiv: begin
              if (bus.b == '0) begin
                result_d = '0;
                error_d  = 1'b1;
                state_d  = StDone;
              end else begin
                state_d = StCalc;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OpMul) begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end else begin
          // Restoring step: the quotient bit enters a_q from the right as the dividend leaves.
          a_d   = (a_q << 1) | WIDTH'(ge);
          rem_d = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d = (op_q == OpMul) ? acc_step : {{WIDTH{1'b0}}, a_d};
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.error     = error_q;
endmodule
